// File: rtl/spi_rx_frame_parser_if.sv
// Byte-in / payload-out bundle of the SPI frame parser.
// master drives bytes and pops, slave is the parser.
interface spi_rx_frame_parser_if;
   logic [7:0] in_data;
   logic       in_ready;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       frame_done;
   logic       frame_err;
   logic       overflow;
   logic [7:0] good_cnt;
   logic [7:0] bad_cnt;

   modport master (
      output in_data, in_ready, rd_en,
      input  rd_data, rd_valid, frame_done, frame_err,
      input  overflow, good_cnt, bad_cnt
   );

   modport slave (
      input  in_data, in_ready, rd_en,
      output rd_data, rd_valid, frame_done, frame_err,
      output overflow, good_cnt, bad_cnt
   );
endinterface

// File: rtl/spi_rx_frame_parser.sv
// SOF/LEN/payload/checksum parser feeding a commit/rollback FIFO.
// FRAME_STATS_EN adds good/bad frame counters.
module spi_rx_frame_parser #(
   parameter int         DEPTH   = 16,
   parameter int         MAX_LEN = 8,
   parameter logic [7:0] SOF     = 8'hA5
) (
   input logic clock,
   input logic reset,
   spi_rx_frame_parser_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

   state_t      state;
   logic        ready_d;
   logic        stb;
   logic        full;
   logic        pop;
   logic        push;
   logic [AW:0] wr_ptr;
   logic [AW:0] commit_ptr;
   logic [AW:0] rd_ptr;
   logic [7:0]  sum;
   logic [7:0]  remaining;
   logic        done_q;
   logic        err_q;
   logic        ovf_q;
   logic [7:0]  mem [DEPTH];

   assign stb  = bus.in_ready & ~ready_d;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop  = bus.rd_en & bus.rd_valid;
   assign push = stb && (state == PAYLOAD) && !full;

   assign bus.rd_valid   = (commit_ptr != rd_ptr);
   assign bus.rd_data    = bus.rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
   assign bus.frame_done = done_q;
   assign bus.frame_err  = err_q;
   assign bus.overflow   = ovf_q;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ready_d    <= 1'b0;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         sum        <= 8'h00;
         remaining  <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         ready_d <= bus.in_ready;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (stb) begin
            unique case (state)
               IDLE: begin
                  if (bus.in_data == SOF) state <= LEN;
               end
               LEN: begin
                  if (bus.in_data == 8'h00 ||
                      bus.in_data > 8'(MAX_LEN)) begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end else begin
                     remaining <= bus.in_data;
                     sum       <= bus.in_data;
                     state     <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  // full counts uncommitted bytes too, so the frame is dropped
                  if (full) begin
                     wr_ptr <= commit_ptr;
                     err_q  <= 1'b1;
                     ovf_q  <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     wr_ptr    <= wr_ptr + 1'b1;
                     sum       <= sum + bus.in_data;
                     remaining <= remaining - 8'd1;
                     if (remaining == 8'd1) state <= CSUM;
                  end
               end
               CSUM: begin
                  if (bus.in_data == sum) begin
                     commit_ptr <= wr_ptr;
                     done_q     <= 1'b1;
                  end else begin
                     wr_ptr <= commit_ptr;
                     err_q  <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef FRAME_STATS_EN
   logic [7:0] good_q;
   logic [7:0] bad_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         good_q <= 8'h00;
         bad_q  <= 8'h00;
      end else begin
         if (done_q) good_q <= good_q + 8'd1;
         if (err_q)  bad_q  <= bad_q + 8'd1;
      end
   end

   assign bus.good_cnt = good_q;
   assign bus.bad_cnt  = bad_q;
`else
   assign bus.good_cnt = 8'h00;
   assign bus.bad_cnt  = 8'h00;
`endif
endmodule

// File: tb/tb_spi_rx_frame_parser.sv
// Scoreboard bench for spi_rx_frame_parser.
// Payload bytes of accepted frames are queued and checked on pop.
module tb_spi_rx_frame_parser;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   spi_rx_frame_parser_if bus ();

   spi_rx_frame_parser #(
      .DEPTH(16),
      .MAX_LEN(8),
      .SOF(8'hA5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_done = 0;
   int         n_err = 0;
   int         e_done = 0;
   int         e_err = 0;
   int         s_good = 0;
   int         s_bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] pl [8];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && (bus.frame_done || bus.frame_err)) begin
         check("excl", 32'(bus.frame_done & bus.frame_err), 0);
         if (bus.frame_done) n_done++;
         if (bus.frame_err)  n_err++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      bus.in_data  = b;
      bus.in_ready = 1'b1;
      repeat (hold) @(negedge clock);
      bus.in_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] len,
                             input logic [7:0] p [8],
                             input bit corrupt);
      logic [7:0] s;
      s = len;
      send_byte(8'hA5, 1);
      send_byte(len, 1);
      for (int i = 0; i < int'(len); i++) begin
         send_byte(p[i], 1);
         s = s + p[i];
      end
      bus.in_data  = corrupt ? s + 8'd1 : s;
      bus.in_ready = 1'b1;
      @(negedge clock);
      if (corrupt) begin
         check("lat_err", 32'(bus.frame_err), 1);
         e_err++;
         s_bad++;
      end else begin
         check("lat_done", 32'(bus.frame_done), 1);
         check("lat_valid", 32'(bus.rd_valid), 1);
         for (int i = 0; i < int'(len); i++) exp_q.push_back(p[i]);
         e_done++;
         s_good++;
      end
      bus.in_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic check_counts(input string tag);
      logic [31:0] g;
      logic [31:0] b;
`ifdef FRAME_STATS_EN
      g = 32'(s_good & 255);
      b = 32'(s_bad & 255);
`else
      g = 0;
      b = 0;
`endif
      check({tag, "_done_n"}, 32'(n_done), 32'(e_done));
      check({tag, "_err_n"}, 32'(n_err), 32'(e_err));
      check({tag, "_good_cnt"}, 32'(bus.good_cnt), g);
      check({tag, "_bad_cnt"}, 32'(bus.bad_cnt), b);
      check({tag, "_valid"}, 32'(bus.rd_valid),
            32'(exp_q.size() != 0));
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 64) begin
         check({tag, "_rvalid"}, 32'(bus.rd_valid), 1);
         check({tag, "_rdata"}, 32'(bus.rd_data),
               32'(exp_q.pop_front()));
         bus.rd_en = 1'b1;
         @(negedge clock);
         bus.rd_en = 1'b0;
         guard++;
      end
      bus.rd_en = 1'b1;
      @(negedge clock);
      bus.rd_en = 1'b0;
      check({tag, "_empty"}, 32'(bus.rd_valid), 0);
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_data  = 8'h00;
      bus.in_ready = 1'b0;
      bus.rd_en    = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_valid", 32'(bus.rd_valid), 0);
      check("rst_data", 32'(bus.rd_data), 0);
      check("rst_done", 32'(bus.frame_done), 0);
      check("rst_err", 32'(bus.frame_err), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_good", 32'(bus.good_cnt), 0);
      check("rst_bad", 32'(bus.bad_cnt), 0);
      reset = 1'b0;
      @(negedge clock);

      pl = '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0};
      send_frame(8'd2, pl, 1'b0);
      check_counts("good");
      drain("good");

      send_frame(8'd2, pl, 1'b1);
      check_counts("badsum");
      drain("badsum");

      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      pl = '{8'h7F, 0, 0, 0, 0, 0, 0, 0};
      send_frame(8'd1, pl, 1'b0);
      check_counts("noise");
      drain("noise");

      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      e_err++;
      s_bad++;
      check_counts("len0");
      send_byte(8'hA5, 1);
      send_byte(8'h09, 1);
      e_err++;
      s_bad++;
      check_counts("len9");

      send_byte(8'hFF, 5);
      check_counts("lvl_idle");
      send_byte(8'hA5, 5);
      send_byte(8'h01, 3);
      send_byte(8'h42, 4);
      send_byte(8'h43, 2);
      exp_q.push_back(8'h42);
      e_done++;
      s_good++;
      check_counts("lvl");
      drain("lvl");

      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_frame(8'd8, pl, 1'b0);
      pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
      send_frame(8'd8, pl, 1'b0);
      check("ovf_pre", 32'(bus.overflow), 0);
      send_byte(8'hA5, 1);
      send_byte(8'h01, 1);
      send_byte(8'h55, 1);
      e_err++;
      s_bad++;
      check("ovf_set", 32'(bus.overflow), 1);
      check_counts("ovf");
      drain("ovf");
      check("ovf_sticky", 32'(bus.overflow), 1);

      send_byte(8'hA5, 1);
      send_byte(8'h03, 1);
      send_byte(8'h10, 1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_valid", 32'(bus.rd_valid), 0);
      check("mid_data", 32'(bus.rd_data), 0);
      check("mid_done", 32'(bus.frame_done), 0);
      check("mid_err", 32'(bus.frame_err), 0);
      check("mid_ovf", 32'(bus.overflow), 0);
      check("mid_good", 32'(bus.good_cnt), 0);
      check("mid_bad", 32'(bus.bad_cnt), 0);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      s_good = 0;
      s_bad  = 0;
      @(negedge clock);
      pl = '{8'h05, 0, 0, 0, 0, 0, 0, 0};
      send_frame(8'd1, pl, 1'b0);
      check_counts("post_rst");
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_rx_frame_parser.md
Name: spi_rx_frame_parser

Overview:
Downstream consumer of the SPI transfer stage. Takes each received byte (out_data qualified by ready) and parses framed packets of the form SOF, LEN, payload, checksum. Payload bytes go into a FIFO with commit/rollback, so the reader sees only payloads whose checksum passed. Per-frame done/error pulses and a sticky overflow flag go to the control side.

Parameters:
DEPTH, 16, payload FIFO entries; power of 2, >= 2
MAX_LEN, 8, largest legal LEN value; 1 <= MAX_LEN <= DEPTH
SOF, 8'hA5, start-of-frame byte value

Ports:
clock  in  1  single clock; all logic updates on its rising edge
reset  in  1  synchronous, active-high reset
in_data  in  8  byte from the SPI stage (its out_data)
in_ready  in  1  SPI stage ready; level, may stay high for several cycles per byte
rd_en  in  1  pop request for the head payload byte
rd_data  out  8  head of the committed FIFO contents, first-word-fall-through
rd_valid  out  1  committed count > 0
frame_done  out  1  one-cycle pulse: frame accepted and committed
frame_err  out  1  one-cycle pulse: frame rejected
overflow  out  1  sticky; set when a payload byte arrives with the FIFO full
good_cnt  out  8  accepted-frame counter (see Optional Feature)
bad_cnt  out  8  rejected-frame counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, ready_d=0, state=IDLE, wr/commit/rd pointers=0, checksum accumulator=0.
- Byte strobe: ready_d registers in_ready; stb = in_ready & ~ready_d. in_data is sampled only in the stb cycle. A level held high for N cycles yields exactly one byte.
- Latency: the checksum byte strobed in cycle N gives frame_done or frame_err high in cycle N+1. rd_valid reflects newly committed bytes from cycle N+1.
- FSM, advanced only on stb:
  - IDLE: byte==SOF -> LEN. Any other byte is discarded silently.
  - LEN: on 0 or >MAX_LEN, pulse frame_err and go to IDLE. Otherwise store remaining=LEN, set sum=LEN, go to PAYLOAD.
  - PAYLOAD: push the byte at wr_ptr, then sum+=byte (mod 256) and remaining-=1. remaining reaching 0 -> CSUM.
  - CSUM: byte==sum: commit_ptr<=wr_ptr, pulse frame_done. Otherwise wr_ptr<=commit_ptr (rollback) and pulse frame_err. Either way go to IDLE.
- Overflow: a PAYLOAD byte arrives when (wr_ptr - rd_ptr)==DEPTH:
  - byte dropped, rollback, frame_err pulse, overflow<=1, state IDLE;
  - overflow clears only on reset.
- Read side:
  - rd_data = mem[rd_ptr];
  - rd_en & rd_valid advances rd_ptr next edge;
  - rd_en while !rd_valid is ignored;
  - a pop in the same cycle as a commit performs both.
- Pointers are log2(DEPTH)+1 bits with wrap-around. Full/empty are derived from the MSB difference.
- SOF inside LEN/PAYLOAD/CSUM is treated as data, with no resync.
- Reset mid-frame discards all FIFO contents, including committed data.
- frame_done and frame_err are never high together.

Optional Feature:
Macro FRAME_STATS_EN.
- Defined: good_cnt increments on each frame_done and bad_cnt on each frame_err. Both are 8-bit, wrap 255->0, and reset to 0.
- Undefined: the counter logic is absent and good_cnt/bad_cnt are tied to 8'h00.

Test Plan:
- Good frame: bytes A5 02 11 22 35, one ready pulse each -> frame_done once; then rd_valid=1, rd_data 11 then 22 on two rd_en pops; rd_valid=0 after.
- Bad checksum: A5 02 11 22 36 -> frame_err once, rd_valid stays 0, FIFO empty; with FRAME_STATS_EN, bad_cnt=1.
- Noise and length check:
  - 00 FF A5 01 7F 80 -> noise ignored, frame_done, rd_data=7F;
  - A5 00 -> immediate frame_err;
  - A5 09 (MAX_LEN=8) -> frame_err.
- Level ready: in_ready held high 5 cycles with in_data=FF, in IDLE -> no state change. A5 held 5 cycles then 01 held 3, 42 held 4, 43 held 2 -> single frame_done, one byte 42.
- Overflow (DEPTH=16, MAX_LEN=8):
  - two 8-byte good frames with no reads -> 16 committed;
  - third frame A5 01 55 -> frame_err and overflow=1;
  - then reading 16 bytes returns the first two payloads intact.
- Reset mid-frame: assert reset after A5 03 10 -> all outputs 0, state IDLE; following A5 01 05 06 -> frame_done, rd_data=05.
